// File: rtl/positron_layer_serializer_pkg.sv
// positron_layer_serializer_pkg
//   Shared types and helpers for the positron layer serializer.
//   - serializer_state_t : collect / stream FSM states
//   - log2()             : ceil(log2(n)), at least 1, used to size the lane index
package positron_layer_serializer_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    STREAM  = 1'b1
  } serializer_state_t;

  // Number of bits needed to index 'value' entries (never less than 1).
  function automatic int unsigned log2(input int unsigned value);
    int unsigned v;
    int unsigned result;
    v      = value - 32'd1;
    result = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if (v != 32'd0) begin
        result = result + 32'd1;
        v      = v >> 1;
      end else begin
        v      = v;
      end
    end
    if (result == 32'd0) begin
      result = 32'd1;
    end else begin
      result = result;
    end
    return result;
  endfunction

endpackage

// File: rtl/positron_layer_serializer_if.sv
// positron_layer_serializer_if
//   Framed posit stream bundle (rts/rtr handshake, sow/eow framing, posit data).
//   NB_LANES = number of parallel lanes; lane k of posit occupies
//   bits [k*POSIT_WIDTH +: POSIT_WIDTH].
//   - master : drives rts, sow, eow, posit; receives rtr
//   - slave  : drives rtr; receives rts, sow, eow, posit
//   The serializer uses a NB_POSITRONS-lane instance as slave (upstream)
//   and a 1-lane instance as master (downstream).
interface positron_layer_serializer_if #(
  parameter int unsigned POSIT_WIDTH = 4,
  parameter int unsigned NB_LANES    = 1
);

  logic [NB_LANES-1:0]             rts;
  logic [NB_LANES-1:0]             rtr;
  logic [NB_LANES-1:0]             sow;
  logic [NB_LANES-1:0]             eow;
  logic [NB_LANES*POSIT_WIDTH-1:0] posit;

  modport master (output rts, output sow, output eow, output posit, input rtr);
  modport slave  (input rts, input sow, input eow, input posit, output rtr);

endinterface

// File: rtl/positron_layer_serializer_lane_reg.sv
// positron_layer_serializer_lane_reg
//   One posit holding register plus its full flag.
//   Ports:
//     clk, rst_n : clock, async active-low reset (clears full and data)
//     set_i      : store data_i and mark full
//     clr_i      : mark empty (wins over set_i)
//     data_i     : posit to store
//     data_o     : stored posit
//     full_o     : lane holds a valid posit
module positron_layer_serializer_lane_reg #(
  parameter int unsigned POSIT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   set_i,
  input  logic                   clr_i,
  input  logic [POSIT_WIDTH-1:0] data_i,
  output logic [POSIT_WIDTH-1:0] data_o,
  output logic                   full_o
);

  logic [POSIT_WIDTH-1:0] data_q, data_d;
  logic                   full_q, full_d;

  // Next-state for the lane: clear has priority so a window boundary always empties the lane.
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (clr_i) begin
      full_d = 1'b0;
    end else if (set_i) begin
      data_d = data_i;
      full_d = 1'b1;
    end else begin
      full_d = full_q;
    end
  end

  // Lane storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/positron_layer_serializer.sv
// positron_layer_serializer
//   Collects one posit per lane from NB_POSITRONS parallel positrons and
//   re-emits the window as a framed serial stream (sow on lane 0, eow on
//   lane NB_POSITRONS-1) for the next positron layer.
//   Ports:
//     clk, rst_n : clock, async active-low reset
//     up_if      : slave, NB_POSITRONS lanes; rtr is per-lane, combinational;
//                  a beat with eow=1 is captured, eow=0 is accepted and dropped
//     dn_if      : master, 1 lane; rts/sow/eow/posit registered
//   Build option:
//     SERIALIZER_DOUBLE_BUFFER_EN : adds a shadow bank filled while streaming;
//     banks swap at the eow transfer, and a full shadow streams with no bubble.
//     Undefined: single bank, upstream rtr is low for the whole stream.
module positron_layer_serializer
  import positron_layer_serializer_pkg::*;
#(
  parameter int unsigned POSIT_WIDTH  = 4,
  parameter int unsigned NB_POSITRONS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  positron_layer_serializer_if.slave  up_if,
  positron_layer_serializer_if.master dn_if
);

  localparam int unsigned IDX_W = log2(NB_POSITRONS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB_POSITRONS - 1);
`ifdef SERIALIZER_DOUBLE_BUFFER_EN
  localparam int unsigned NB_BANKS = 2;
`else
  localparam int unsigned NB_BANKS = 1;
`endif

  // Lane storage, per bank.
  logic [NB_BANKS-1:0][NB_POSITRONS-1:0]                  full_s;
  logic [NB_BANKS-1:0][NB_POSITRONS-1:0]                  set_s;
  logic [NB_BANKS-1:0][NB_POSITRONS-1:0]                  clr_s;
  logic [NB_BANKS-1:0][NB_POSITRONS-1:0][POSIT_WIDTH-1:0] data_s;
  logic [NB_POSITRONS-1:0][POSIT_WIDTH-1:0]               lane_in_s;

  // Views of the bank being filled and the bank being streamed.
  logic [NB_POSITRONS-1:0]                  fill_full_s;
  logic [NB_POSITRONS-1:0][POSIT_WIDTH-1:0] fill_data_s;
  logic [NB_POSITRONS-1:0][POSIT_WIDTH-1:0] stream_data_s;
  logic                                     open_s;

  // Capture and handshake.
  logic [NB_POSITRONS-1:0] rtr_s;
  logic [NB_POSITRONS-1:0] cap_s;
  logic [NB_POSITRONS-1:0] fill_full_nx_s;
  logic [POSIT_WIDTH-1:0]  fill_lane0_nx_s;
  logic                    xfer_s;
  logic                    last_xfer_s;
  logic                    swap_ready_s;
  logic [IDX_W-1:0]        idx_inc_s;

  // FSM and output registers.
  serializer_state_t      state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   rts_q, rts_d;
  logic                   sow_q, sow_d;
  logic                   eow_q, eow_d;
  logic [POSIT_WIDTH-1:0] posit_q, posit_d;

  for (genvar k = 0; k < NB_POSITRONS; k++) begin : g_unpack
    assign lane_in_s[k] = up_if.posit[k*POSIT_WIDTH +: POSIT_WIDTH];
  end

  for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
    for (genvar k = 0; k < NB_POSITRONS; k++) begin : g_lane
      positron_layer_serializer_lane_reg #(
        .POSIT_WIDTH(POSIT_WIDTH)
      ) u_lane (
        .clk    (clk),
        .rst_n  (rst_n),
        .set_i  (set_s[b][k]),
        .clr_i  (clr_s[b][k]),
        .data_i (lane_in_s[k]),
        .data_o (data_s[b][k]),
        .full_o (full_s[b][k])
      );
    end
  end

`ifdef SERIALIZER_DOUBLE_BUFFER_EN
  logic bank_q, bank_d;
  logic fill_bank_s;

  // Bank views: bank_q is streamed; while streaming the other bank is filled.
  always_comb begin
    fill_bank_s = (state_q == STREAM) ? ~bank_q : bank_q;
    open_s      = 1'b1;
    if (fill_bank_s) begin
      fill_full_s = full_s[1'b1];
      fill_data_s = data_s[1'b1];
    end else begin
      fill_full_s = full_s[1'b0];
      fill_data_s = data_s[1'b0];
    end
    if (bank_q) begin
      stream_data_s = data_s[1'b1];
    end else begin
      stream_data_s = data_s[1'b0];
    end
  end

  // Route captures to the fill bank, empty the streamed bank at its eow transfer, swap banks.
  always_comb begin
    set_s = '0;
    clr_s = '0;
    if (fill_bank_s) begin
      set_s[1'b1] = cap_s;
    end else begin
      set_s[1'b0] = cap_s;
    end
    if (last_xfer_s) begin
      if (bank_q) begin
        clr_s[1'b1] = '1;
      end else begin
        clr_s[1'b0] = '1;
      end
    end else begin
      clr_s = '0;
    end
    swap_ready_s = &fill_full_nx_s;
    bank_d       = bank_q ^ last_xfer_s;
  end

  // Active bank pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q <= 1'b0;
    end else begin
      bank_q <= bank_d;
    end
  end
`else
  // Single bank: lanes only open while collecting.
  always_comb begin
    fill_full_s   = full_s;
    fill_data_s   = data_s;
    stream_data_s = data_s;
    open_s        = (state_q == COLLECT);
  end

  // Captures go to the only bank; the whole bank empties at the eow transfer.
  always_comb begin
    set_s        = cap_s;
    clr_s        = {NB_POSITRONS{last_xfer_s}};
    swap_ready_s = 1'b0;
  end
`endif

  // Per-lane handshake and lookahead of the fill bank after this edge's captures.
  always_comb begin
    rtr_s          = ~fill_full_s & {NB_POSITRONS{open_s}};
    cap_s          = rtr_s & up_if.rts & up_if.eow;
    fill_full_nx_s = fill_full_s | cap_s;
    // Lane 0 may be captured on the very edge that completes the window.
    fill_lane0_nx_s = cap_s[0] ? lane_in_s[0] : fill_data_s[0];
    xfer_s          = rts_q & dn_if.rtr;
    last_xfer_s     = xfer_s & eow_q;
    idx_inc_s       = idx_q + IDX_W'(1);
  end

  // FSM next state and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rts_d   = rts_q;
    sow_d   = sow_q;
    eow_d   = eow_q;
    posit_d = posit_q;
    case (state_q)
      COLLECT: begin
        if (&fill_full_nx_s) begin
          state_d = STREAM;
          idx_d   = '0;
          rts_d   = 1'b1;
          sow_d   = 1'b1;
          eow_d   = 1'b0;
          posit_d = fill_lane0_nx_s;
        end else begin
          rts_d = 1'b0;
          sow_d = 1'b0;
          eow_d = 1'b0;
        end
      end
      STREAM: begin
        if (last_xfer_s) begin
          idx_d = '0;
          if (swap_ready_s) begin
            // Shadow bank already complete: start its window back-to-back.
            rts_d   = 1'b1;
            sow_d   = 1'b1;
            eow_d   = 1'b0;
            posit_d = fill_lane0_nx_s;
          end else begin
            state_d = COLLECT;
            rts_d   = 1'b0;
            sow_d   = 1'b0;
            eow_d   = 1'b0;
          end
        end else if (xfer_s) begin
          idx_d   = idx_inc_s;
          sow_d   = 1'b0;
          eow_d   = (idx_inc_s == IDX_LAST);
          posit_d = stream_data_s[idx_inc_s];
        end else begin
          // Downstream stall: hold the current word.
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = COLLECT;
        idx_d   = '0;
        rts_d   = 1'b0;
        sow_d   = 1'b0;
        eow_d   = 1'b0;
      end
    endcase
  end

  // FSM state, lane index and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      rts_q   <= 1'b0;
      sow_q   <= 1'b0;
      eow_q   <= 1'b0;
      posit_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rts_q   <= rts_d;
      sow_q   <= sow_d;
      eow_q   <= eow_d;
      posit_q <= posit_d;
    end
  end

  assign up_if.rtr   = rtr_s;
  assign dn_if.rts   = rts_q;
  assign dn_if.sow   = sow_q;
  assign dn_if.eow   = eow_q;
  assign dn_if.posit = posit_q;

endmodule

// File: tb/tb_positron_layer_serializer.sv
// tb_positron_layer_serializer
//   Directed bench for positron_layer_serializer with POSIT_WIDTH=4,
//   NB_POSITRONS=4. Covers SERIALIZER_DOUBLE_BUFFER_EN when it is defined.
module tb_positron_layer_serializer;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  positron_layer_serializer_if #(.POSIT_WIDTH(4), .NB_LANES(4)) up_if ();
  positron_layer_serializer_if #(.POSIT_WIDTH(4), .NB_LANES(1)) dn_if ();

  positron_layer_serializer #(
    .POSIT_WIDTH  (4),
    .NB_POSITRONS (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .up_if (up_if),
    .dn_if (dn_if)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (got !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a full window on all lanes for one edge; words packed lane3..lane0.
  task automatic offer(input logic [15:0] words);
    up_if.rts   = 4'hF;
    up_if.eow   = 4'hF;
    up_if.posit = words;
    tick();
    up_if.rts   = 4'h0;
  endtask

  // Expect a window already presenting word 0, with rtr_i high; leaves after the eow transfer.
  task automatic expect_window(input logic [15:0] words, input string tag);
    logic [15:0] w;
    w = words;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("%s_rts%0d", tag, i), {31'd0, dn_if.rts}, 32'd1);
      check_eq($sformatf("%s_posit%0d", tag, i), {28'd0, dn_if.posit}, {28'd0, w[i*4 +: 4]});
      check_eq($sformatf("%s_sow%0d", tag, i), {31'd0, dn_if.sow}, (i == 0) ? 32'd1 : 32'd0);
      check_eq($sformatf("%s_eow%0d", tag, i), {31'd0, dn_if.eow}, (i == 3) ? 32'd1 : 32'd0);
`ifndef SERIALIZER_DOUBLE_BUFFER_EN
      check_eq($sformatf("%s_rtr_busy%0d", tag, i), {28'd0, up_if.rtr}, 32'd0);
`endif
      tick();
      up_if.rts = 4'h0;
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    up_if.rts    = 4'h0;
    up_if.eow    = 4'h0;
    up_if.sow    = 4'h0;
    up_if.posit  = 16'h0000;
    dn_if.rtr    = 1'b1;

    // 1. Reset values.
    tick();
    tick();
    check_eq("rst_rts", {31'd0, dn_if.rts}, 32'd0);
    check_eq("rst_sow", {31'd0, dn_if.sow}, 32'd0);
    check_eq("rst_eow", {31'd0, dn_if.eow}, 32'd0);
    check_eq("rst_posit", {28'd0, dn_if.posit}, 32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("rst_rtr", {28'd0, up_if.rtr}, 32'hF);

    // 2. Full window in one beat, 1-cycle latency, then the lanes reopen.
    offer(16'h4321);
    expect_window(16'h4321, "basic");
    check_eq("basic_end_rts", {31'd0, dn_if.rts}, 32'd0);
    check_eq("basic_end_rtr", {28'd0, up_if.rtr}, 32'hF);

    // 3. Staggered capture, with a dropped eow=0 beat on lane 1.
    up_if.rts = 4'b0100; up_if.eow = 4'b0100; up_if.posit = 16'h0700;
    tick();
    check_eq("stag_rtr_l2", {28'd0, up_if.rtr}, 32'hB);
    up_if.rts = 4'b0001; up_if.eow = 4'b0001; up_if.posit = 16'h0009;
    tick();
    up_if.rts = 4'b0010; up_if.eow = 4'b0000; up_if.posit = 16'h00E0;
    tick();
    check_eq("stag_drop_rtr", {28'd0, up_if.rtr}, 32'hA);
    up_if.rts = 4'b1000; up_if.eow = 4'b1000; up_if.posit = 16'hA000;
    tick();
    check_eq("stag_not_early", {31'd0, dn_if.rts}, 32'd0);
    up_if.rts = 4'b0010; up_if.eow = 4'b0010; up_if.posit = 16'h00B0;
    tick();
    up_if.rts = 4'h0;
    expect_window(16'hA7B9, "stag");
    check_eq("stag_end_rts", {31'd0, dn_if.rts}, 32'd0);

    // 4. Backpressure on word 0x2.
    offer(16'h4321);
    check_eq("bp_w1", {28'd0, dn_if.posit}, 32'h1);
    tick();
    dn_if.rtr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("bp_hold_posit%0d", i), {28'd0, dn_if.posit}, 32'h2);
      check_eq($sformatf("bp_hold_rts%0d", i), {31'd0, dn_if.rts}, 32'd1);
      check_eq($sformatf("bp_hold_sow%0d", i), {31'd0, dn_if.sow}, 32'd0);
    end
    dn_if.rtr = 1'b1;
    tick();
    check_eq("bp_w3", {28'd0, dn_if.posit}, 32'h3);
    check_eq("bp_w3_eow", {31'd0, dn_if.eow}, 32'd0);
    tick();
    check_eq("bp_w4", {28'd0, dn_if.posit}, 32'h4);
    check_eq("bp_w4_eow", {31'd0, dn_if.eow}, 32'd1);
    tick();
    check_eq("bp_end_rts", {31'd0, dn_if.rts}, 32'd0);

    // 5. Reset in the middle of a window, then a clean window.
    offer(16'h4321);
    tick();
    tick();
    check_eq("mrst_pre_posit", {28'd0, dn_if.posit}, 32'h3);
    rst_n = 1'b0;
    #1;
    check_eq("mrst_rts", {31'd0, dn_if.rts}, 32'd0);
    check_eq("mrst_posit", {28'd0, dn_if.posit}, 32'd0);
    check_eq("mrst_sow_eow", {30'd0, dn_if.sow, dn_if.eow}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("mrst_no_partial", {31'd0, dn_if.rts}, 32'd0);
    check_eq("mrst_rtr", {28'd0, up_if.rtr}, 32'hF);
    offer(16'h8765);
    expect_window(16'h8765, "post_rst");
    check_eq("post_rst_end", {31'd0, dn_if.rts}, 32'd0);

`ifdef SERIALIZER_DOUBLE_BUFFER_EN
    // 6. Shadow bank captured while window A streams: no bubble between windows.
    offer(16'h4321);
    check_eq("db_rtr_open", {28'd0, up_if.rtr}, 32'hF);
    up_if.rts   = 4'hF;
    up_if.eow   = 4'hF;
    up_if.posit = 16'hFEDC;
    expect_window(16'h4321, "db_a");
    expect_window(16'hFEDC, "db_b");
    check_eq("db_end_rts", {31'd0, dn_if.rts}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
